fifo_wr_serializer: RTL and testbench
=====================================

# fifo_wr_serializer

Write-side feeder for the async byte FIFO: accepts LANES-byte words on a valid/ready stream in the wr_clk domain and serializes them into one-byte FIFO writes, lane 0 first. It drives the FIFO's wr_en and write_data directly and back-pressures on the FIFO's full flag. Sustains one byte per cycle with no bubble between consecutive words. Keeps a running count of bytes written.

## Interface
- DATA, 8, FIFO byte width (bits per lane)
- LANES, 4, lanes per input word (>=2)
- CNT_W, 16, width of byte_count
- wr_clk  in  1  write-domain clock
- wrst_n  in  1  synchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts word this cycle
- in_data  in  DATA*LANES  input word; lane i = bits [i*DATA +: DATA]
- in_len  in  $clog2(LANES+1)  valid lanes, counted from lane 0; 0..LANES
- full  in  1  FIFO full flag (combinational from FIFO)
- wr_en  out  1  FIFO write strobe
- write_data  out  DATA  FIFO write byte
- busy  out  1  word held, bytes pending
- byte_count  out  CNT_W  bytes written since reset, wraps modulo 2^CNT_W

## Operation
- Reset: wrst_n sampled on wr_clk only (synchronous, active-low).
- States: IDLE (nothing held), SHIFT (remaining > 0 bytes held).
- Registers: hold[DATA*LANES], remaining[$clog2(LANES+1)], state, byte_count.
- Transfer: word accepted when in_valid && in_ready.
- in_ready = wrst_n && (state==IDLE || (wr_en && remaining==1)).
- wr_en = wrst_n && state==SHIFT && !full; write_data = hold[DATA-1:0]; busy = (state==SHIFT).
- Each wr_en cycle: hold shifts right by DATA, remaining decrements, byte_count increments.
- On accept: hold <= in_data, remaining <= min(in_len, LANES).
- in_len == 0: word accepted and discarded; state stays/returns IDLE, no write.
- in_len > LANES: clamped to LANES.
- Last byte + new word in same cycle: the new word loads and state stays SHIFT. No idle cycle.
- Last byte, no new word: state -> IDLE.
- full high in SHIFT: wr_en=0; hold, remaining and byte_count frozen; in_ready=0.
- Lanes at index >= in_len are never written.

## Timing
- Reset values: state IDLE, remaining 0, hold 0, byte_count 0.
- During reset cycles: in_ready=0, wr_en=0, busy=0, write_data=0.
- First cycle after reset release: in_ready=1.
- Latency: word accepted at edge N gives first wr_en in cycle N+1 (full low). Byte k is written at cycle N+1+k when never stalled.
- Throughput: 1 byte/cycle. A LANES-byte word occupies LANES cycles.
- wr_en and in_ready are combinational on full and must not glitch-depend on in_valid. in_ready is independent of in_valid.
- Reset mid-word: pending bytes are dropped. No wr_en on the reset cycle or after it. byte_count clears.
- byte_count wraps from 2^CNT_W-1 to 0.

## Structure
- Shared package fifo_pkg:
  - DATA default
  - state typedef (enum IDLE, SHIFT)
- No sub-module is needed; the block is a single flat module.
- Instantiated beside the FIFO, connected by wr_en, write_data and full.

## Test plan
- Single full word: in_data=0x44332211, in_len=4, full=0 -> wr_en for 4 cycles with bytes 11,22,33,44. in_ready=1 on the 4th write. byte_count=4.
- Back-to-back words: 0x44332211 then 0x88776655, both len 4, in_valid held -> 8 consecutive wr_en cycles with bytes 11..88 and no gap. byte_count=8.
- Partial and zero length: 0xAABBCCDD with len=2 -> bytes DD,CC only. Then a word with len=0 -> accepted, no wr_en, busy stays 0.
- Full back-pressure: full raised for 3 cycles after the first byte of 0x44332211 -> wr_en=0 and in_ready=0 while full. Bytes 22,33,44 follow after release, none lost or duplicated.
- Reset mid-word: wrst_n low after 2 of 4 bytes -> wr_en=0 from the reset cycle on, byte_count=0, busy=0. After release in_ready=1 and the next word starts at lane 0.
- Counter wrap (CNT_W=4): 5 four-byte words -> byte_count=4 (20 mod 16).

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the async byte FIFO and its write-side feeder.
package fifo_pkg;

    localparam int FIFO_DATA = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } wr_state_t;

endpackage

// File: rtl/fifo_wr_serializer.sv
// Serializes LANES-byte input words into one-byte FIFO writes, lane 0 first,
// stalling on the FIFO full flag and counting every byte written.
module fifo_wr_serializer
    import fifo_pkg::*;
#(
    parameter int DATA  = FIFO_DATA,
    parameter int LANES = 4,
    parameter int CNT_W = 16,
    localparam int LW   = $clog2(LANES + 1)
) (
    input  logic                  wr_clk,
    input  logic                  wrst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA*LANES-1:0] in_data,
    input  logic [LW-1:0]         in_len,
    input  logic                  full,
    output logic                  wr_en,
    output logic [DATA-1:0]       write_data,
    output logic                  busy,
    output logic [CNT_W-1:0]      byte_count
);

    localparam logic [LW-1:0] LANES_L = LW'(LANES);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    wr_state_t             state_reg, state_next;
    logic [DATA*LANES-1:0] hold_reg, hold_next, hold_shifted;
    logic [LW-1:0]         remaining_reg, remaining_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [LW-1:0]         len_clamped;
    logic                  accept;

    // Next lane moves down into lane 0; the top lane fills with zeros.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_shift
        if (gi == LANES - 1) begin : g_top
            assign hold_shifted[gi*DATA +: DATA] = '0;
        end else begin : g_mid
            assign hold_shifted[gi*DATA +: DATA] = hold_reg[(gi+1)*DATA +: DATA];
        end
    end

    assign len_clamped = (in_len > LANES_L) ? LANES_L : in_len;

    // Output gating on wrst_n keeps the FIFO quiet on the cycle reset is applied.
    assign wr_en      = wrst_n && (state_reg == SHIFT) && !full;
    assign in_ready   = wrst_n && ((state_reg == IDLE) || (wr_en && remaining_reg == ONE_L));
    assign accept     = in_valid && in_ready;
    assign write_data = wrst_n ? hold_reg[DATA-1:0] : '0;
    assign busy       = wrst_n && (state_reg == SHIFT);
    assign byte_count = count_reg;

    always_comb begin
        state_next     = state_reg;
        hold_next      = hold_reg;
        remaining_next = remaining_reg;
        count_next     = count_reg;
        // A word arriving with the last byte takes priority over the shift.
        if (accept) begin
            hold_next      = in_data;
            remaining_next = len_clamped;
            state_next     = (len_clamped == '0) ? IDLE : SHIFT;
        end else if (wr_en) begin
            hold_next      = hold_shifted;
            remaining_next = remaining_reg - ONE_L;
            if (remaining_reg == ONE_L) begin
                state_next = IDLE;
            end
        end
        if (wr_en) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge wr_clk) begin
        if (!wrst_n) begin
            state_reg     <= IDLE;
            hold_reg      <= '0;
            remaining_reg <= '0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            remaining_reg <= remaining_next;
            count_reg     <= count_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_serializer.sv
// Directed bench for fifo_wr_serializer (LANES=4, CNT_W=4 so the wrap is reachable).
module tb_fifo_wr_serializer;

    localparam int DATA  = 8;
    localparam int LANES = 4;
    localparam int CNT_W = 4;
    localparam int LW    = $clog2(LANES + 1);

    logic                  wr_clk = 1'b0;
    logic                  wrst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA*LANES-1:0] in_data;
    logic [LW-1:0]         in_len;
    logic                  full;
    logic                  wr_en;
    logic [DATA-1:0]       write_data;
    logic                  busy;
    logic [CNT_W-1:0]      byte_count;

    int tests_run    = 0;
    int tests_failed = 0;

    fifo_wr_serializer #(
        .DATA  (DATA),
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) dut (
        .wr_clk     (wr_clk),
        .wrst_n     (wrst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_len     (in_len),
        .full       (full),
        .wr_en      (wr_en),
        .write_data (write_data),
        .busy       (busy),
        .byte_count (byte_count)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        wrst_n   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_len   = '0;
        full     = 1'b0;
        #1;
        check_val("rst_wr_en", 32'(wr_en), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_write_data", 32'(write_data), 32'd0);
        check_val("rst_byte_count", 32'(byte_count), 32'd0);
        wrst_n = 1'b1;
        #1;
        check_val("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Sends one word, optionally raising full for stall_cycles before byte stall_at.
    task automatic send_word(input logic [31:0] d, input logic [LW-1:0] len,
                             input int stall_at, input int stall_cycles);
        int nb;
        nb = (int'(len) > LANES) ? LANES : int'(len);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = len;
        #1;
        check_val("accept_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < nb; k++) begin
            if (k == stall_at) begin
                full = 1'b1;
                for (int s = 0; s < stall_cycles; s++) begin
                    #1;
                    check_val("stall_wr_en", 32'(wr_en), 32'd0);
                    check_val("stall_in_ready", 32'(in_ready), 32'd0);
                    check_val("stall_busy", 32'(busy), 32'd1);
                    tick();
                end
                full = 1'b0;
            end
            #1;
            check_val($sformatf("byte%0d_wr_en", k), 32'(wr_en), 32'd1);
            check_val($sformatf("byte%0d_data", k), 32'(write_data), (d >> (8 * k)) & 32'hFF);
            check_val($sformatf("byte%0d_in_ready", k), 32'(in_ready), (k == nb - 1) ? 32'd1 : 32'd0);
            tick();
        end
        #1;
        check_val("word_done_wr_en", 32'(wr_en), 32'd0);
        check_val("word_done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [63:0] b2b;
        // Single full word
        do_reset();
        send_word(32'h44332211, 3'd4, -1, 0);
        check_val("single_count", 32'(byte_count), 32'd4);

        // Back-to-back words, in_valid held throughout
        do_reset();
        b2b      = 64'h8877665544332211;
        in_valid = 1'b1;
        in_data  = 32'h44332211;
        in_len   = 3'd4;
        tick();
        in_data = 32'h88776655;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_val($sformatf("b2b%0d_wr_en", k), 32'(wr_en), 32'd1);
            check_val($sformatf("b2b%0d_data", k), 32'(write_data), 32'((b2b >> (8 * k)) & 64'hFF));
            tick();
            if (k == 3) in_valid = 1'b0;
        end
        #1;
        check_val("b2b_idle", 32'(wr_en), 32'd0);
        check_val("b2b_count", 32'(byte_count), 32'd8);

        // Partial, zero and over-length words
        do_reset();
        send_word(32'hAABBCCDD, 3'd2, -1, 0);
        check_val("partial_count", 32'(byte_count), 32'd2);
        send_word(32'h12345678, 3'd0, -1, 0);
        check_val("zero_len_count", 32'(byte_count), 32'd2);
        send_word(32'hF0E0D0C0, 3'd7, -1, 0);
        check_val("clamp_count", 32'(byte_count), 32'd6);

        // Full back-pressure after the first byte
        do_reset();
        send_word(32'h44332211, 3'd4, 1, 3);
        check_val("stall_count", 32'(byte_count), 32'd4);

        // Reset mid-word
        do_reset();
        in_valid = 1'b1;
        in_data  = 32'h44332211;
        in_len   = 3'd4;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_val($sformatf("pre_rst%0d_data", k), 32'(write_data), (32'h44332211 >> (8 * k)) & 32'hFF);
            tick();
        end
        check_val("pre_rst_count", 32'(byte_count), 32'd2);
        wrst_n = 1'b0;
        #1;
        check_val("midrst_wr_en", 32'(wr_en), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        tick();
        check_val("midrst_count", 32'(byte_count), 32'd0);
        check_val("midrst_wr_en2", 32'(wr_en), 32'd0);
        wrst_n = 1'b1;
        #1;
        check_val("midrst_release_ready", 32'(in_ready), 32'd1);
        check_val("midrst_release_wr_en", 32'(wr_en), 32'd0);
        send_word(32'hDDCCBBAA, 3'd4, -1, 0);
        check_val("midrst_after_count", 32'(byte_count), 32'd4);

        // Counter wrap: 20 bytes mod 16
        do_reset();
        for (int w = 0; w < 5; w++) begin
            send_word(32'h01020304 + 32'(w), 3'd4, -1, 0);
        end
        check_val("wrap_count", 32'(byte_count), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
